prog_loader: RTL and testbench
==============================

# prog_loader

Program-memory writer and fetch responder for the 16-entry, 8-bit accumulator core. It receives a framed byte stream over a valid/ready link and writes the payload into a 16x8 program RAM. Until a complete, correctly checked frame has been stored, it holds the core in reset through `core_rstn`. While the core runs, it answers instruction fetches (`fetch_addr` to `fetch_instr`), replacing the core's hard-coded program.

## Interface
- `DEPTH`, default 16: program RAM entries.
- `AW`, default 4: address width, equal to clog2(`DEPTH`).
- `DW`, default 8: instruction and byte width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: a byte is offered on `in_data`.
- `in_data` input `DW`: stream byte.
- `in_ready` output 1: the loader accepts a byte this cycle. A byte transfers when `in_valid` and `in_ready` are both high.
- `reload` input 1: single-cycle pulse that discards the current program and re-arms loading.
- `fetch_addr` input `AW`: core program counter.
- `fetch_instr` output `DW`: instruction at `fetch_addr`, combinational.
- `core_rstn` output 1: active-low reset to the core. It is high only in RUN.
- `load_done` output 1: a valid program is resident and the core is released.
- `load_err` output 1: the last frame was rejected.

## Operation
- **Frame format:** `SYNC` (8'hA5), then `LEN`, then `LEN` payload bytes, then `CSUM`.
  - `LEN` must be in the range 1..`DEPTH`.
  - `CSUM` is valid when (`LEN` + all payload + `CSUM`) mod 256 == 0.
- **FSM states:** WAIT_SYNC, GET_LEN, GET_DATA, GET_CSUM, RUN, ERROR.
- **WAIT_SYNC:**
  - A non-SYNC byte is consumed and dropped.
  - `SYNC` moves to GET_LEN, clears the running sum and the write pointer, and clears `load_err`.
- **GET_LEN:**
  - `LEN` of 0 or greater than `DEPTH` moves to ERROR.
  - A legal `LEN` is latched into `len_q`, seeds the sum, and moves to GET_DATA.
- **GET_DATA:**
  - Each accepted byte is written to RAM[`wptr`], `wptr` increments, and the byte is added to the sum.
  - After byte `LEN` is accepted, the FSM moves to GET_CSUM.
  - `wptr` never wraps, because `LEN` ≤ `DEPTH`.
- **GET_CSUM:**
  - If (sum + byte) mod 256 == 0, the FSM moves to RUN.
  - Otherwise it moves to ERROR.
- **RUN:**
  - `in_ready` is 0.
  - Only `reload` leaves RUN; it returns to WAIT_SYNC.
- **ERROR:**
  - `load_err` is 1 and `in_ready` is 1.
  - Bytes are consumed. `SYNC` behaves as it does in WAIT_SYNC.
  - `reload` moves to WAIT_SYNC and clears `load_err`.
- **Fetch read:**
  - In RUN, `fetch_addr` < `len_q` returns the RAM contents.
  - In RUN, `fetch_addr` ≥ `len_q` returns HLT (8'hFF).
  - In any state other than RUN, the read returns NOP (8'h00).
- `reload` in any state returns to WAIT_SYNC and discards any partial frame. A byte offered in the same cycle as `reload` is not accepted.
- A failed frame leaves `core_rstn` low. RAM contents after a failed frame are don't-care, because `len_q` is invalidated.

## Timing
- **Reset values:**
  - State is WAIT_SYNC.
  - `in_ready` is 0 while `rst` is high.
  - `core_rstn` = 0, `load_done` = 0, `load_err` = 0.
  - `len_q` = 0 and `wptr` = 0.
  - RAM contents are not reset.
- `in_ready` is a decode of the state: 1 in WAIT_SYNC, GET_LEN, GET_DATA, GET_CSUM and ERROR, and 0 in RUN. It is forced to 0 during `rst`.
- One byte is accepted per cycle maximum. Back-to-back `in_valid` gives a full frame in `LEN` + 3 cycles.
- A RAM write commits at the edge that accepts the byte.
- At the edge that accepts a good `CSUM`, the FSM enters RUN. In the following cycle `core_rstn` = 1 and `load_done` = 1.
- ERROR, and `load_err` = 1, become visible in the cycle after the offending byte.
- At the edge after a `reload` pulse, `core_rstn` = 0 and `load_done` = 0.
- `fetch_instr` has zero latency.
- `rst` asserted mid-frame aborts the frame at the next edge, with every output returning to its reset value.

## Configuration
- `PROG_LOADER_CSUM_EN` defined:
  - The frame includes `CSUM` and GET_CSUM exists.
- `PROG_LOADER_CSUM_EN` undefined:
  - GET_CSUM and the sum logic are removed.
  - After payload byte `LEN` is accepted, the FSM goes directly to RUN.
  - `load_err` is raised only for an illegal `LEN`.

## Structure
- **`prog_loader_pkg`:**
  - State enum.
  - Constants `SYNC_BYTE` = 8'hA5, `HLT_OP` = 8'hFF, `NOP_OP` = 8'h00.
  - Default `DEPTH`.
- **Sub-module `prog_ram`:**
  - `DEPTH` x `DW` storage.
  - One synchronous write port.
  - One asynchronous read port.
- The FSM, sum, `wptr`, `len_q` and fetch muxing live in `prog_loader`.

## Test plan
- **Good load, then run.** Stream A5 06 91 61 15 16 A7 FF 37 with no gaps.
  - Required: `load_done` and `core_rstn` rise one cycle after 37 is accepted.
  - Required: `fetch_addr` 0..5 returns 91 61 15 16 A7 FF.
  - Required: `fetch_addr` 9 returns FF.
- **Bad checksum.** Stream the same frame with `CSUM` = 38.
  - Required: `load_err` = 1, `core_rstn` stays 0, `fetch_instr` = 00.
  - Then stream a good frame. Required: `load_err` clears on `SYNC` and `load_done` = 1.
- **Illegal `LEN`.** Stream A5 00, and separately A5 11.
  - Required: ERROR on the `LEN` byte and no RAM writes.
  - Required: with the macro off, the same `LEN` errors still occur.
- **Garbage and gaps.** Stream 00 12 A5 01 AA 55 with `in_valid` low on alternate cycles.
  - Required: the leading bytes are dropped.
  - Required: the load succeeds (01 + AA + 55 = 100).
  - Required: fetch 0 returns AA and fetch 1 returns FF.
- **Reload and reset mid-frame.**
  - `reload` during GET_DATA. Required: WAIT_SYNC next cycle, and the next good frame loads cleanly.
  - `reload` in RUN while `in_valid` is high. Required: the byte is not accepted and `core_rstn` falls.
  - `rst` in GET_CSUM. Required: all outputs return to their reset values.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and opcode constants for the program loader.
package prog_loader_pkg;
   typedef enum logic [2:0] {WAIT_SYNC, GET_LEN, GET_DATA, GET_CSUM, RUN, ERROR} state_t;
   localparam int DEPTH_DEF = 16;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] HLT_OP = 8'hFF;
   localparam logic [7:0] NOP_OP = 8'h00;
endpackage

// File: rtl/prog_loader_ram.sv
// prog_ram: DEPTH x DW program store, one synchronous write port and one asynchronous read port.
module prog_ram #(
   parameter int DEPTH = 16,
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed-byte program loader and fetch responder; holds the core in reset until a good frame lands.
// Define PROG_LOADER_CSUM_EN to require and check the trailing checksum byte.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW = $clog2(DEPTH),
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic          reload,
   input  logic [AW-1:0] fetch_addr,
   output logic [DW-1:0] fetch_instr,
   output logic          core_rstn,
   output logic          load_done,
   output logic          load_err
);
   localparam logic [DW-1:0] DEPTH_B = DW'(DEPTH);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
   state_t state, nxt;
   logic [AW:0] len_q, wptr;
   logic [DW-1:0] rdata;
   logic acc, is_sync, bad_len, last;
   assign acc = in_valid && in_ready && !reload;
   assign is_sync = in_data == DW'(SYNC_BYTE);
   assign bad_len = in_data == '0 || in_data > DEPTH_B;
   assign last = (wptr + ONE) == len_q;
`ifdef PROG_LOADER_CSUM_EN
   logic [DW-1:0] sum;
   logic csum_ok;
   assign csum_ok = (sum + in_data) == '0;
   always_ff @(posedge clk)
      if (rst) sum <= '0;
      else if (acc && (state == WAIT_SYNC || state == ERROR) && is_sync) sum <= '0;
      else if (acc && state == GET_LEN) sum <= in_data;
      else if (acc && state == GET_DATA) sum <= sum + in_data;
`endif
   always_ff @(posedge clk)
      if (rst) state <= WAIT_SYNC;
      else state <= nxt;
   always_comb begin
      nxt = state;
      if (reload) nxt = WAIT_SYNC;
      else if (acc)
         case (state)
            WAIT_SYNC, ERROR: nxt = is_sync ? GET_LEN : state;
            GET_LEN: nxt = bad_len ? ERROR : GET_DATA;
`ifdef PROG_LOADER_CSUM_EN
            GET_DATA: nxt = last ? GET_CSUM : GET_DATA;
            GET_CSUM: nxt = csum_ok ? RUN : ERROR;
`else
            GET_DATA: nxt = last ? RUN : GET_DATA;
`endif
            default: nxt = state;
         endcase
   end
   // len_q is zeroed whenever the resident program stops being trustworthy
   always_ff @(posedge clk)
      if (rst || reload) begin
         len_q <= '0;
         wptr <= '0;
      end else if (acc && (state == WAIT_SYNC || state == ERROR) && is_sync) begin
         len_q <= '0;
         wptr <= '0;
      end else if (acc && state == GET_LEN && !bad_len) len_q <= in_data[AW:0];
      else if (acc && state == GET_DATA) wptr <= wptr + ONE;
`ifdef PROG_LOADER_CSUM_EN
      else if (acc && state == GET_CSUM && !csum_ok) len_q <= '0;
`endif
   always_comb begin
      in_ready = !rst && state != RUN;
      core_rstn = state == RUN;
      load_done = state == RUN;
      load_err = state == ERROR;
      fetch_instr = state != RUN ? DW'(NOP_OP) : ({1'b0, fetch_addr} < len_q) ? rdata : DW'(HLT_OP);
   end
   prog_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
      .clk(clk),
      .we(acc && state == GET_DATA),
      .waddr(wptr[AW-1:0]),
      .wdata(in_data),
      .raddr(fetch_addr),
      .rdata(rdata)
   );
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader; expectations track PROG_LOADER_CSUM_EN.
module tb_prog_loader;
   logic clk = 0, rst = 1, in_valid = 0, reload = 0;
   logic [7:0] in_data = 0;
   logic [3:0] fetch_addr = 0;
   logic in_ready, core_rstn, load_done, load_err;
   logic [7:0] fetch_instr;
   int tests = 0, fails = 0;
   prog_loader dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .reload(reload), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
      .core_rstn(core_rstn), .load_done(load_done), .load_err(load_err)
   );
   always #5 clk = ~clk;
   task automatic put(input logic [7:0] b);
      in_valid = 1;
      in_data = b;
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask
   task automatic idle();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reload();
      reload = 1;
      @(posedge clk);
      #1;
      reload = 0;
   endtask
   task automatic test_reset();
      rst = 1;
      idle();
      idle();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      tests++; if (core_rstn !== 1'b0) begin fails++; $display("FAIL reset_core_rstn got %b exp 0", core_rstn); end
      tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_load_done got %b exp 0", load_done); end
      tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL reset_load_err got %b exp 0", load_err); end
      tests++; if (fetch_instr !== 8'h00) begin fails++; $display("FAIL reset_fetch got %h exp 00", fetch_instr); end
      rst = 0;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
   endtask
   task automatic test_good_load();
      logic [7:0] exp [6] = '{8'h91, 8'h61, 8'h15, 8'h16, 8'hA7, 8'hFF};
      put(8'hA5); put(8'h06);
      for (int i = 0; i < 5; i++) put(exp[i]);
`ifdef PROG_LOADER_CSUM_EN
      put(8'hFF);
      tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL good_early_done got %b exp 0", load_done); end
      put(8'h37);
`else
      tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL good_early_done got %b exp 0", load_done); end
      put(8'hFF);
`endif
      tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL good_load_done got %b exp 1", load_done); end
      tests++; if (core_rstn !== 1'b1) begin fails++; $display("FAIL good_core_rstn got %b exp 1", core_rstn); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL good_run_in_ready got %b exp 0", in_ready); end
      for (int i = 0; i < 6; i++) begin
         fetch_addr = 4'(i);
         #1;
         tests++; if (fetch_instr !== exp[i]) begin fails++; $display("FAIL good_fetch%0d got %h exp %h", i, fetch_instr, exp[i]); end
      end
      fetch_addr = 4'd9;
      #1;
      tests++; if (fetch_instr !== 8'hFF) begin fails++; $display("FAIL good_fetch9 got %h exp FF", fetch_instr); end
   endtask
`ifdef PROG_LOADER_CSUM_EN
   task automatic test_bad_csum();
      logic [7:0] fr [8] = '{8'h06, 8'h91, 8'h61, 8'h15, 8'h16, 8'hA7, 8'hFF, 8'h37};
      do_reload();
      put(8'hA5);
      for (int i = 0; i < 7; i++) put(fr[i]);
      put(8'h38);
      fetch_addr = 0;
      #1;
      tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL badcs_err got %b exp 1", load_err); end
      tests++; if (core_rstn !== 1'b0) begin fails++; $display("FAIL badcs_core_rstn got %b exp 0", core_rstn); end
      tests++; if (fetch_instr !== 8'h00) begin fails++; $display("FAIL badcs_fetch got %h exp 00", fetch_instr); end
      put(8'hA5);
      tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL badcs_err_clear got %b exp 0", load_err); end
      for (int i = 0; i < 8; i++) put(fr[i]);
      tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL badcs_recover got %b exp 1", load_done); end
   endtask
`else
   task automatic test_no_csum();
      do_reload();
      put(8'hA5); put(8'h01); put(8'h91);
      tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL nocs_done got %b exp 1", load_done); end
      fetch_addr = 1;
      #1;
      tests++; if (fetch_instr !== 8'hFF) begin fails++; $display("FAIL nocs_fetch1 got %h exp FF", fetch_instr); end
   endtask
`endif
   task automatic test_illegal_len();
      do_reload();
      put(8'hA5); put(8'h00);
      tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL len0_err got %b exp 1", load_err); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL len0_in_ready got %b exp 1", in_ready); end
      put(8'h33);
      put(8'hA5);
      tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL len_sync_clear got %b exp 0", load_err); end
      put(8'h11);
      tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL len17_err got %b exp 1", load_err); end
      put(8'h33); put(8'h33);
      tests++; if (dut.u_ram.mem[0] !== 8'h91) begin fails++; $display("FAIL len_nowrite0 got %h exp 91", dut.u_ram.mem[0]); end
      tests++; if (dut.u_ram.mem[1] !== 8'h61) begin fails++; $display("FAIL len_nowrite1 got %h exp 61", dut.u_ram.mem[1]); end
      tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL len_no_run got %b exp 0", load_done); end
   endtask
   task automatic test_gaps();
      logic [7:0] s [6] = '{8'h00, 8'h12, 8'hA5, 8'h01, 8'hAA, 8'h55};
      do_reload();
      for (int i = 0; i < 6; i++) begin
         put(s[i]);
         if (i == 1) begin
            tests++; if (load_err !== 1'b0 || load_done !== 1'b0) begin fails++; $display("FAIL gap_garbage got err=%b done=%b exp 0 0", load_err, load_done); end
         end
         idle();
      end
      tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL gap_done got %b exp 1", load_done); end
      fetch_addr = 0;
      #1;
      tests++; if (fetch_instr !== 8'hAA) begin fails++; $display("FAIL gap_fetch0 got %h exp AA", fetch_instr); end
      fetch_addr = 1;
      #1;
      tests++; if (fetch_instr !== 8'hFF) begin fails++; $display("FAIL gap_fetch1 got %h exp FF", fetch_instr); end
   endtask
   task automatic test_reload_mid();
      do_reload();
      put(8'hA5); put(8'h03); put(8'h11); put(8'h22);
      do_reload();
      tests++; if (in_ready !== 1'b1 || load_err !== 1'b0) begin fails++; $display("FAIL rl_mid_state got rdy=%b err=%b exp 1 0", in_ready, load_err); end
      put(8'h33);
      put(8'hA5); put(8'h02); put(8'h44); put(8'h55);
`ifdef PROG_LOADER_CSUM_EN
      put(8'h65);
`endif
      tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL rl_mid_done got %b exp 1", load_done); end
      fetch_addr = 0;
      #1;
      tests++; if (fetch_instr !== 8'h44) begin fails++; $display("FAIL rl_mid_fetch0 got %h exp 44", fetch_instr); end
      fetch_addr = 1;
      #1;
      tests++; if (fetch_instr !== 8'h55) begin fails++; $display("FAIL rl_mid_fetch1 got %h exp 55", fetch_instr); end
      fetch_addr = 2;
      #1;
      tests++; if (fetch_instr !== 8'hFF) begin fails++; $display("FAIL rl_mid_fetch2 got %h exp FF", fetch_instr); end
   endtask
   task automatic test_reload_run();
      for (int k = 0; k < 2; k++) begin
         in_valid = 1;
         in_data = 8'hA5;
         reload = 1;
         @(posedge clk);
         #1;
         reload = 0;
         in_valid = 0;
         tests++; if (core_rstn !== 1'b0 || load_done !== 1'b0) begin fails++; $display("FAIL rl_run%0d_rstn got %b/%b exp 0/0", k, core_rstn, load_done); end
         put(8'h01); put(8'h66);
`ifdef PROG_LOADER_CSUM_EN
         put(8'h99);
`endif
         tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL rl_run%0d_sync_taken got %b exp 0", k, load_done); end
      end
   endtask
   task automatic test_rst_mid();
      do_reload();
      put(8'hA5); put(8'h03); put(8'h44); put(8'h55);
`ifdef PROG_LOADER_CSUM_EN
      put(8'h66);
`endif
      rst = 1;
      fetch_addr = 0;
      idle();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_in_ready got %b exp 0", in_ready); end
      tests++; if (core_rstn !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin fails++; $display("FAIL rst_mid_outs got %b%b%b exp 000", core_rstn, load_done, load_err); end
      tests++; if (fetch_instr !== 8'h00) begin fails++; $display("FAIL rst_mid_fetch got %h exp 00", fetch_instr); end
      rst = 0;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_release got %b exp 1", in_ready); end
      put(8'h02);
      tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL rst_mid_wait_sync got %b exp 0", load_err); end
   endtask
   initial begin
      test_reset();
      test_good_load();
`ifdef PROG_LOADER_CSUM_EN
      test_bad_csum();
`else
      test_no_csum();
`endif
      test_illegal_len();
      test_gaps();
      test_reload_mid();
      test_reload_run();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
